// File: rtl/fsm_wd_pkg.sv
// Shared types and constants for the watchdog-guarded actuator/tub sequencer.
package fsm_wd_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'b000,
    S_TEST      = 3'b001,
    S_WAIT_FLAG = 3'b010,
    S_WAIT_DONE = 3'b011,
    S_FAULT     = 3'b100
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_READY_TO = 2'b01;
  localparam logic [1:0] FC_DONE_TO  = 2'b10;

  // Counter must hold the larger limit; keep at least one bit when both are disabled.
  function automatic int wdWidth(input int readyTo, input int doneTo);
    int maxLim;
    maxLim = (readyTo > doneTo) ? readyTo : doneTo;
    return (maxLim < 1) ? 1 : $clog2(maxLim + 1);
  endfunction

endpackage

// File: rtl/fsm_wd_ctrl_wd_timer.sv
// Watchdog counter: counts enabled cycles and flags the last allowed one.
module wd_timer #(
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_expire
);

  logic [W-1:0] r_wd;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wd <= '0;
    end else if (i_clr) begin
      r_wd <= '0;
    end else if (i_en) begin
      r_wd <= r_wd + 1'b1;
    end
  end

  // A zero limit disables expiry; the counter may wrap harmlessly then.
  assign o_expire = i_en && (i_limit != '0) && (r_wd == i_limit - 1'b1);

endmodule

// File: rtl/fsm_wd_ctrl.sv
// Start/ready/done sequencer with watchdog faults, abort and a saturating cycle count.
module fsm_wd_ctrl
  import fsm_wd_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int READY_TO = 16,
  parameter int DONE_TO  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_ready,
  input  logic             i_done,
  input  logic             i_abort,
  input  logic             i_clr_fault,
  output logic             o_enable_act,
  output logic             o_enable_tub,
  output logic             o_count,
  output logic [CNT_W-1:0] o_cycles,
  output logic             o_busy,
  output logic             o_fault,
  output logic [1:0]       o_fault_code
);

  localparam int WD_W = wdWidth(READY_TO, DONE_TO);
  localparam logic [WD_W-1:0]  READY_LIM = WD_W'(READY_TO);
  localparam logic [WD_W-1:0]  DONE_LIM  = WD_W'(DONE_TO);
  localparam logic [CNT_W-1:0] CYC_MAX   = '1;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_fault_code;
  logic [1:0]        w_fault_code_next;
  logic [CNT_W-1:0]  r_cycles;
  logic              w_enable_act;
  logic              w_count;
  logic              w_wd_en;
  logic              w_wd_clr;
  logic              w_expire;
  logic [WD_W-1:0]   w_limit;

  assign w_wd_en  = (r_state == S_WAIT_FLAG) || (r_state == S_WAIT_DONE);
  assign w_wd_clr = (w_next != r_state);
  assign w_limit  = (r_state == S_WAIT_FLAG) ? READY_LIM : DONE_LIM;

  wd_timer #(.W(WD_W)) u_wd (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .i_limit  (w_limit),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_fault_code <= FC_NONE;
      r_cycles     <= '0;
    end else begin
      r_state      <= w_next;
      r_fault_code <= w_fault_code_next;
      if (w_count && (r_cycles != CYC_MAX)) begin
        r_cycles <= r_cycles + 1'b1;
      end
    end
  end

  // Within a wait state: abort beats the awaited flag, which beats the watchdog.
  always_comb begin
    w_next            = r_state;
    w_fault_code_next = r_fault_code;
    w_enable_act      = 1'b0;
    w_count           = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          w_next       = S_TEST;
          w_enable_act = 1'b1;
        end
      end
      S_TEST: begin
        if (i_abort)      w_next = S_IDLE;
        else if (i_ready) w_next = S_WAIT_DONE;
        else              w_next = S_WAIT_FLAG;
      end
      S_WAIT_FLAG: begin
        if (i_abort) begin
          w_next = S_IDLE;
        end else if (i_ready) begin
          w_next = S_WAIT_DONE;
        end else if (w_expire) begin
          w_next            = S_FAULT;
          w_fault_code_next = FC_READY_TO;
        end
      end
      S_WAIT_DONE: begin
        if (i_abort) begin
          w_next = S_IDLE;
        end else if (i_done) begin
          w_next  = S_IDLE;
          w_count = 1'b1;
        end else if (w_expire) begin
          w_next            = S_FAULT;
          w_fault_code_next = FC_DONE_TO;
        end
      end
      S_FAULT: begin
        if (i_clr_fault) begin
          w_next            = S_IDLE;
          w_fault_code_next = FC_NONE;
        end
      end
      default: begin
        w_next            = S_IDLE;
        w_fault_code_next = FC_NONE;
      end
    endcase
  end

  assign o_enable_act = w_enable_act;
  assign o_count      = w_count;
  assign o_enable_tub = (r_state == S_WAIT_DONE);
  assign o_busy       = (r_state != S_IDLE) && (r_state != S_FAULT);
  assign o_fault      = (r_state == S_FAULT);
  assign o_fault_code = r_fault_code;
  assign o_cycles     = r_cycles;

endmodule

// File: tb/tb_fsm_wd_ctrl.sv
// Scoreboard bench: three controller instances (nominal, 2-bit counter, watchdog off) on shared stimulus.
module tb_fsm_wd_ctrl;

  // Output vector {enable_act, enable_tub, count, busy, fault, fault_code[1:0]}
  localparam logic [6:0] O_IDLE  = 7'b0000000;
  localparam logic [6:0] O_START = 7'b1000000;
  localparam logic [6:0] O_BUSY  = 7'b0001000;
  localparam logic [6:0] O_WDONE = 7'b0101000;
  localparam logic [6:0] O_DONEP = 7'b0111000;
  localparam logic [6:0] O_F1    = 7'b0000101;
  localparam logic [6:0] O_F2    = 7'b0000110;

  // Input vector {start, ready, done, abort, clr_fault}
  localparam logic [4:0] I_NONE  = 5'b00000;
  localparam logic [4:0] I_START = 5'b10000;
  localparam logic [4:0] I_READY = 5'b01000;
  localparam logic [4:0] I_DONE  = 5'b00100;
  localparam logic [4:0] I_ABORT = 5'b00010;
  localparam logic [4:0] I_CLR   = 5'b00001;

  typedef struct {
    string      tag;
    int         sel;
    logic [6:0] outs;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, ready = 1'b0, done = 1'b0, abort = 1'b0, clrFault = 1'b0;

  logic       actA, tubA, cntA, busyA, faultA;
  logic [1:0] codeA;
  logic [7:0] cycA;
  logic       actB, tubB, cntB, busyB, faultB;
  logic [1:0] codeB;
  logic [1:0] cycB;
  logic       actC, tubC, cntC, busyC, faultC;
  logic [1:0] codeC;
  logic [7:0] cycC;

  int   total = 0;
  int   bad   = 0;
  int   dutSel = 0;
  exp_t sb[$];
  exp_t item;

  always #5 clk = ~clk;

  fsm_wd_ctrl #(.CNT_W(8), .READY_TO(16), .DONE_TO(16)) u_main (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_ready(ready), .i_done(done),
    .i_abort(abort), .i_clr_fault(clrFault), .o_enable_act(actA), .o_enable_tub(tubA),
    .o_count(cntA), .o_cycles(cycA), .o_busy(busyA), .o_fault(faultA), .o_fault_code(codeA));

  fsm_wd_ctrl #(.CNT_W(2), .READY_TO(16), .DONE_TO(16)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_ready(ready), .i_done(done),
    .i_abort(abort), .i_clr_fault(clrFault), .o_enable_act(actB), .o_enable_tub(tubB),
    .o_count(cntB), .o_cycles(cycB), .o_busy(busyB), .o_fault(faultB), .o_fault_code(codeB));

  fsm_wd_ctrl #(.CNT_W(8), .READY_TO(0), .DONE_TO(0)) u_nowd (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_ready(ready), .i_done(done),
    .i_abort(abort), .i_clr_fault(clrFault), .o_enable_act(actC), .o_enable_tub(tubC),
    .o_count(cntC), .o_cycles(cycC), .o_busy(busyC), .o_fault(faultC), .o_fault_code(codeC));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the outputs must show.
  task automatic applyStimulus(input string tag, input logic [4:0] in,
                               input logic [6:0] outs, input int cyc);
    exp_t e;
    @(negedge clk);
    {start, ready, done, abort, clrFault} = in;
    e.tag = tag; e.sel = dutSel; e.outs = outs; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic repeatStimulus(input string tag, input int n, input logic [4:0] in,
                                input logic [6:0] outs, input int cyc);
    for (int i = 0; i < n; i++) applyStimulus(tag, in, outs, cyc);
  endtask

  // Reset is raised between clock edges, so the zero outputs prove it acts asynchronously.
  task automatic doReset(input string tag);
    exp_t e;
    @(negedge clk);
    rst = 1'b1;
    {start, ready, done, abort, clrFault} = I_NONE;
    e.tag = tag; e.sel = dutSel; e.outs = O_IDLE; e.cyc = 0;
    sb.push_back(e);
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    #1;
    if (sb.size() > 0) begin
      item = sb.pop_front();
      case (item.sel)
        0: begin
          checkOutput({item.tag, ".outs"}, 32'({actA, tubA, cntA, busyA, faultA, codeA}), 32'(item.outs));
          checkOutput({item.tag, ".cycles"}, 32'(cycA), 32'(item.cyc));
        end
        1: begin
          checkOutput({item.tag, ".outs"}, 32'({actB, tubB, cntB, busyB, faultB, codeB}), 32'(item.outs));
          checkOutput({item.tag, ".cycles"}, 32'(cycB), 32'(item.cyc));
        end
        default: begin
          checkOutput({item.tag, ".outs"}, 32'({actC, tubC, cntC, busyC, faultC, codeC}), 32'(item.outs));
          checkOutput({item.tag, ".cycles"}, 32'(cycC), 32'(item.cyc));
        end
      endcase
    end
  end

  initial begin
    dutSel = 0;
    doReset("reset");
    applyStimulus("idle", I_NONE, O_IDLE, 0);

    applyStimulus("basic.start", I_START, O_START, 0);
    applyStimulus("basic.test", I_READY, O_BUSY, 0);
    applyStimulus("basic.done", I_DONE, O_DONEP, 0);
    applyStimulus("basic.idle", I_NONE, O_IDLE, 1);

    applyStimulus("slow.start", I_START, O_START, 1);
    applyStimulus("slow.test", I_NONE, O_BUSY, 1);
    repeatStimulus("slow.wait", 15, I_NONE, O_BUSY, 1);
    applyStimulus("slow.ready16", I_READY, O_BUSY, 1);
    applyStimulus("slow.done", I_DONE, O_DONEP, 1);
    applyStimulus("slow.idle", I_NONE, O_IDLE, 2);

    applyStimulus("rto.start", I_START, O_START, 2);
    applyStimulus("rto.test", I_NONE, O_BUSY, 2);
    repeatStimulus("rto.wait", 16, I_NONE, O_BUSY, 2);
    applyStimulus("rto.fault", I_NONE, O_F1, 2);
    applyStimulus("rto.ignore", I_START | I_READY | I_DONE, O_F1, 2);
    applyStimulus("rto.abort", I_ABORT, O_F1, 2);
    applyStimulus("rto.clr", I_CLR, O_F1, 2);
    applyStimulus("rto.idle", I_NONE, O_IDLE, 2);

    applyStimulus("dto.start", I_START, O_START, 2);
    applyStimulus("dto.test", I_READY, O_BUSY, 2);
    repeatStimulus("dto.wait", 16, I_NONE, O_WDONE, 2);
    applyStimulus("dto.fault", I_NONE, O_F2, 2);
    applyStimulus("dto.clr", I_CLR, O_F2, 2);
    applyStimulus("dto.idle", I_NONE, O_IDLE, 2);

    applyStimulus("edge.start", I_START, O_START, 2);
    applyStimulus("edge.test", I_READY, O_BUSY, 2);
    repeatStimulus("edge.wait", 15, I_NONE, O_WDONE, 2);
    applyStimulus("edge.done16", I_DONE, O_DONEP, 2);
    applyStimulus("edge.idle", I_NONE, O_IDLE, 3);

    applyStimulus("abd.start", I_START, O_START, 3);
    applyStimulus("abd.test", I_READY, O_BUSY, 3);
    applyStimulus("abd.abortdone", I_DONE | I_ABORT, O_WDONE, 3);
    applyStimulus("abd.idle", I_NONE, O_IDLE, 3);
    applyStimulus("abs.startabort", I_START | I_ABORT, O_IDLE, 3);
    applyStimulus("abs.idle", I_NONE, O_IDLE, 3);
    applyStimulus("abf.start", I_START, O_START, 3);
    applyStimulus("abf.test", I_NONE, O_BUSY, 3);
    applyStimulus("abf.abort", I_ABORT, O_BUSY, 3);
    applyStimulus("abf.idle", I_NONE, O_IDLE, 3);

    applyStimulus("b2b.start", I_START, O_START, 3);
    applyStimulus("b2b.test", I_READY, O_BUSY, 3);
    applyStimulus("b2b.done", I_DONE, O_DONEP, 3);
    applyStimulus("b2b.start2", I_START, O_START, 4);
    applyStimulus("b2b.test2", I_READY, O_BUSY, 4);
    applyStimulus("b2b.done2", I_DONE, O_DONEP, 4);
    applyStimulus("b2b.idle", I_NONE, O_IDLE, 5);

    applyStimulus("rwf.start", I_START, O_START, 5);
    applyStimulus("rwf.test", I_NONE, O_BUSY, 5);
    applyStimulus("rwf.wait", I_NONE, O_BUSY, 5);
    doReset("rwf.reset");
    applyStimulus("rwf.idle", I_NONE, O_IDLE, 0);

    applyStimulus("rfl.start", I_START, O_START, 0);
    applyStimulus("rfl.test", I_READY, O_BUSY, 0);
    applyStimulus("rfl.done", I_DONE, O_DONEP, 0);
    applyStimulus("rfl.start2", I_START, O_START, 1);
    applyStimulus("rfl.test2", I_NONE, O_BUSY, 1);
    repeatStimulus("rfl.wait", 16, I_NONE, O_BUSY, 1);
    applyStimulus("rfl.fault", I_NONE, O_F1, 1);
    doReset("rfl.reset");
    applyStimulus("rfl.idle", I_NONE, O_IDLE, 0);

    dutSel = 1;
    doReset("sat.reset");
    for (int k = 0; k < 5; k++) begin
      applyStimulus("sat.start", I_START, O_START, (k > 3) ? 3 : k);
      applyStimulus("sat.test", I_READY, O_BUSY, (k > 3) ? 3 : k);
      applyStimulus("sat.done", I_DONE, O_DONEP, (k > 3) ? 3 : k);
    end
    applyStimulus("sat.idle", I_NONE, O_IDLE, 3);

    dutSel = 2;
    doReset("nowd.reset");
    applyStimulus("nowd.start", I_START, O_START, 0);
    applyStimulus("nowd.test", I_NONE, O_BUSY, 0);
    repeatStimulus("nowd.flag", 40, I_NONE, O_BUSY, 0);
    applyStimulus("nowd.ready", I_READY, O_BUSY, 0);
    repeatStimulus("nowd.wdone", 40, I_NONE, O_WDONE, 0);
    applyStimulus("nowd.done", I_DONE, O_DONEP, 0);
    applyStimulus("nowd.idle", I_NONE, O_IDLE, 1);

    @(negedge clk);
    {start, ready, done, abort, clrFault} = I_NONE;
    @(negedge clk);
    #3;
    checkOutput("drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
